// File: rtl/adc_sample_filter_if.sv
// DRP sample-in / filtered-result-out bundle for adc_sample_filter.
// The master drives the DRP strobe and data; the slave is the filter itself.
interface adc_sample_filter_if;
  logic        drdy_in;
  logic [15:0] do_in;
  logic [11:0] sample_out;
  logic        sample_valid;
  logic        window_full;
  logic        voltage_low;

  modport master (
    output drdy_in, do_in,
    input  sample_out, sample_valid, window_full, voltage_low
  );

  modport slave (
    input  drdy_in, do_in,
    output sample_out, sample_valid, window_full, voltage_low
  );
endinterface

// File: rtl/adc_sample_filter.sv
// Boxcar average of XADC DRP codes feeding a hysteresis low-voltage flag.
// Optional debounce of the flag is enabled by defining ADC_FILT_DEBOUNCE_EN.
module adc_sample_filter #(
  parameter int unsigned AVG_LOG2 = 3,
  parameter logic [11:0] LOW_TH   = 12'hE1A,
  parameter logic [11:0] HIGH_TH  = 12'hE3C,
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic                clk,
  input  logic                reset_in,
  adc_sample_filter_if.slave  bus
);

  localparam int unsigned DEPTH = 1 << AVG_LOG2;
  localparam int unsigned PW    = (AVG_LOG2 == 0) ? 1 : AVG_LOG2;
  localparam int unsigned FW    = AVG_LOG2 + 1;
  localparam int unsigned SW    = 12 + AVG_LOG2;

  typedef enum logic {FILL, RUN} state_t;

  state_t          state;
  logic [11:0]     win_buf [DEPTH];
  logic [PW-1:0]   ptr;
  logic [FW-1:0]   fill_cnt;
  logic [SW-1:0]   sum;
  logic            sum_valid;
  logic [11:0]     raw;
  logic            ptr_last;
  logic            fill_last;
  logic            cand_low;
  logic            cand_high;
  logic            opposing;
  logic            unused_lsb;

  assign raw        = bus.do_in[15:4];
  assign unused_lsb = ^bus.do_in[3:0];
  assign ptr_last   = (ptr == PW'(DEPTH - 1));
  assign fill_last  = (fill_cnt == FW'(DEPTH - 1));

  always_comb begin
    cand_low  = (bus.sample_out < LOW_TH);
    cand_high = (bus.sample_out > HIGH_TH);
    opposing  = bus.voltage_low ? cand_high : cand_low;
  end

  // Window storage is deliberately left out of reset; FILL overwrites it
  // before any subtraction ever reads it.
  always_ff @(posedge clk) begin
    if (!reset_in && bus.drdy_in) win_buf[ptr] <= raw;
  end

`ifdef ADC_FILT_DEBOUNCE_EN
  logic [3:0] db_cnt;
`else
  localparam int unsigned unused_debounce = DEBOUNCE;
`endif

  always_ff @(posedge clk) begin
    if (reset_in) begin
      state            <= FILL;
      ptr              <= '0;
      fill_cnt         <= '0;
      sum              <= '0;
      sum_valid        <= 1'b0;
      bus.window_full  <= 1'b0;
      bus.sample_out   <= '0;
      bus.sample_valid <= 1'b0;
      bus.voltage_low  <= 1'b0;
`ifdef ADC_FILT_DEBOUNCE_EN
      db_cnt           <= '0;
`endif
    end else begin
      sum_valid <= 1'b0;
      if (bus.drdy_in) begin
        ptr <= ptr_last ? '0 : ptr + 1'b1;
        case (state)
          FILL: begin
            sum      <= sum + SW'(raw);
            fill_cnt <= fill_cnt + 1'b1;
            if (fill_last) begin
              state           <= RUN;
              bus.window_full <= 1'b1;
              sum_valid       <= 1'b1;
            end
          end
          RUN: begin
            sum       <= sum + SW'(raw) - SW'(win_buf[ptr]);
            sum_valid <= 1'b1;
          end
          default: state <= FILL;
        endcase
      end

      bus.sample_valid <= sum_valid;
      if (sum_valid) bus.sample_out <= 12'(sum >> AVG_LOG2);

      if (bus.sample_valid) begin
`ifdef ADC_FILT_DEBOUNCE_EN
        if (opposing) begin
          if (db_cnt + 4'd1 == 4'(DEBOUNCE)) begin
            bus.voltage_low <= ~bus.voltage_low;
            db_cnt          <= '0;
          end else begin
            db_cnt <= db_cnt + 4'd1;
          end
        end else begin
          db_cnt <= '0;
        end
`else
        if (opposing) bus.voltage_low <= ~bus.voltage_low;
`endif
      end
    end
  end

endmodule

// File: tb/tb_adc_sample_filter.sv
// Directed, table-driven bench for adc_sample_filter (AVG_LOG2=3, default thresholds).
module tb_adc_sample_filter;

  logic clk = 1'b0;
  logic reset_in = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  adc_sample_filter_if bus();

  adc_sample_filter #(
    .AVG_LOG2(3),
    .LOW_TH(12'hE1A),
    .HIGH_TH(12'hE3C),
    .DEBOUNCE(4)
  ) dut (
    .clk(clk),
    .reset_in(reset_in),
    .bus(bus)
  );

  typedef struct {
    logic [11:0] code;
    logic        exp_valid;
    logic [11:0] exp_avg;
    logic        exp_low;
    logic        exp_full;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic [11:0] code, logic v, logic [11:0] avg, logic low, logic full);
    vec_t r;
    r.code = code; r.exp_valid = v; r.exp_avg = avg; r.exp_low = low; r.exp_full = full;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    step();
    step();
    reset_in = 1'b0;
  endtask

  // One strobe at cycle N; results checked at N+2 (average) and N+3 (flag).
  task automatic apply_vec(input vec_t v, input string tag);
    bus.drdy_in = 1'b1;
    bus.do_in   = {v.code, 4'h5};
    step();
    bus.drdy_in = 1'b0;
    bus.do_in   = '0;
    step();
    check({tag, " valid"}, 32'(bus.sample_valid), 32'(v.exp_valid));
    check({tag, " full"}, 32'(bus.window_full), 32'(v.exp_full));
    if (v.exp_valid) check({tag, " avg"}, 32'(bus.sample_out), 32'(v.exp_avg));
    step();
    check({tag, " low"}, 32'(bus.voltage_low), 32'(v.exp_low));
    check({tag, " pulse"}, 32'(bus.sample_valid), 32'd0);
  endtask

`ifndef ADC_FILT_DEBOUNCE_EN
  logic [11:0] hy_a [8] = '{12'hE04, 12'hE08, 12'hE0C, 12'hE10, 12'hE14, 12'hE18, 12'hE1C, 12'hE20};
  logic [11:0] hy_b [8] = '{12'hE23, 12'hE27, 12'hE2A, 12'hE2E, 12'hE31, 12'hE35, 12'hE38, 12'hE3C};
  logic [11:0] alt_a [8] = '{12'hE35, 12'hE35, 12'hE2E, 12'hE2E, 12'hE26, 12'hE27, 12'hE1F, 12'hE20};
`else
  logic [11:0] db_code [8] = '{12'hDE8, 12'hDE8, 12'hDE8, 12'hE98, 12'hC00, 12'hC00, 12'hC00, 12'hC00};
  logic [11:0] db_avg  [8] = '{12'hE19, 12'hE12, 12'hE0B, 12'hE1A, 12'hDD6, 12'hD92, 12'hD4E, 12'hD0A};
`endif

  initial begin
    int cnt, first, last;
    bus.drdy_in = 1'b0;
    bus.do_in   = '0;
    step();
    do_reset();
    check("rst sample_out", 32'(bus.sample_out), 32'd0);
    check("rst sample_valid", 32'(bus.sample_valid), 32'd0);
    check("rst window_full", 32'(bus.window_full), 32'd0);
    check("rst voltage_low", 32'(bus.voltage_low), 32'd0);

`ifndef ADC_FILT_DEBOUNCE_EN
    for (int i = 0; i < 7; i++) vecs.push_back(mk(12'hE00, 1'b0, 12'h0, 1'b0, 1'b0));
    vecs.push_back(mk(12'hE00, 1'b1, 12'hE00, 1'b1, 1'b1));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(12'hE20, 1'b1, hy_a[i], 1'b1, 1'b1));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(12'hE3C, 1'b1, hy_b[i], 1'b1, 1'b1));
    for (int i = 0; i < 7; i++) vecs.push_back(mk(12'hE3D, 1'b1, 12'hE3C, 1'b1, 1'b1));
    vecs.push_back(mk(12'hE3D, 1'b1, 12'hE3D, 1'b0, 1'b1));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk((i % 2 == 0) ? 12'hE00 : 12'hE40, 1'b1, alt_a[i], 1'b0, 1'b1));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk((i % 2 == 0) ? 12'hE00 : 12'hE40, 1'b1, 12'hE20, 1'b0, 1'b1));
`else
    for (int i = 0; i < 7; i++) vecs.push_back(mk(12'hE20, 1'b0, 12'h0, 1'b0, 1'b0));
    vecs.push_back(mk(12'hE20, 1'b1, 12'hE20, 1'b0, 1'b1));
    for (int i = 0; i < 8; i++) vecs.push_back(mk(db_code[i], 1'b1, db_avg[i], (i == 7), 1'b1));
`endif
    for (int i = 0; i < vecs.size(); i++) apply_vec(vecs[i], $sformatf("vec%0d", i));

    // Back-to-back strobes: 20 cycles of drdy, pulses expected in cycles 10..22.
    do_reset();
    cnt = 0; first = 0; last = 0;
    for (int cyc = 1; cyc <= 32; cyc++) begin
      bus.drdy_in = (cyc <= 20);
      bus.do_in   = 16'hE000;
      if (bus.sample_valid) begin
        cnt++;
        if (first == 0) first = cyc;
        last = cyc;
        check($sformatf("thru avg c%0d", cyc), 32'(bus.sample_out), 32'hE00);
      end
      step();
    end
    bus.drdy_in = 1'b0;
    check("thru count", 32'(cnt), 32'd13);
    check("thru first", 32'(first), 32'd10);
    check("thru last", 32'(last), 32'd22);
    check("thru low", 32'(bus.voltage_low), 32'd1);

    // Reset one cycle after a full-window strobe: its result must be dropped.
    bus.drdy_in = 1'b1;
    step();
    bus.drdy_in = 1'b0;
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pipe rst valid%0d", i), 32'(bus.sample_valid), 32'd0);
      step();
    end
    check("pipe rst low", 32'(bus.voltage_low), 32'd0);
    check("pipe rst full", 32'(bus.window_full), 32'd0);
    check("pipe rst out", 32'(bus.sample_out), 32'd0);

    // Reset mid-fill with drdy held during reset; old data must not leak.
    for (int i = 0; i < 5; i++) apply_vec(mk(12'h000, 1'b0, 12'h0, 1'b0, 1'b0), $sformatf("mf pre%0d", i));
    reset_in    = 1'b1;
    bus.drdy_in = 1'b1;
    bus.do_in   = '0;
    step();
    step();
    reset_in    = 1'b0;
    bus.drdy_in = 1'b0;
    check("mf full", 32'(bus.window_full), 32'd0);
    for (int i = 0; i < 7; i++) apply_vec(mk(12'hE40, 1'b0, 12'h0, 1'b0, 1'b0), $sformatf("mf%0d", i));
    apply_vec(mk(12'hE40, 1'b1, 12'hE40, 1'b0, 1'b1), "mf7");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule

// File: doc/adc_sample_filter.md
# adc_sample_filter

Conditions XADC auxiliary-channel conversion results before they reach the power-save modulator's PWM gate. Captures each DRP read result (12-bit code in `do_in[15:4]`) on the ADC data-ready strobe and keeps a running boxcar average over 2^AVG_LOG2 samples. It applies a hysteresis comparator, with optional debounce, to the average and drives `voltage_low`. The modulator ANDs `voltage_low` with its PWM stream.

## Interface
- AVG_LOG2, 3, log2 of averaging window length; legal 0..5
- LOW_TH, 12'hE1A, average strictly below this sets the low candidate
- HIGH_TH, 12'hE3C, average strictly above this sets the high candidate; must exceed LOW_TH
- DEBOUNCE, 4, consecutive agreeing averages needed to flip `voltage_low`; legal 1..15; used only with ADC_FILT_DEBOUNCE_EN
- clk  input  1  single clock; ADC DRP clock domain
- reset_in  input  1  synchronous, active-high reset
- drdy_in  input  1  one-cycle DRP data-ready strobe
- do_in  input  16  DRP read data; bits [15:4] are the 12-bit code
- sample_out  output  12  latest window average
- sample_valid  output  1  one-cycle pulse when `sample_out` updates
- window_full  output  1  window holds 2^AVG_LOG2 samples since reset
- voltage_low  output  1  hysteresis/debounced low-voltage flag

## Operation
- Storage is a circular buffer of 2^AVG_LOG2 × 12-bit entries, plus a write pointer, a fill counter, and a running sum of 12+AVG_LOG2 bits.
- The state machine has two states, FILL and RUN.
  - Reset enters FILL.
  - On each `drdy_in` in FILL, `raw` is written at the write pointer, `sum <= sum + raw`, and the pointer increments.
  - The drdy that writes the last entry moves the FSM to RUN and sets `window_full`.
  - In RUN, each drdy sets `sum <= sum + raw - buf[ptr]` and `buf[ptr] <= raw`.
  - The pointer wraps from 2^AVG_LOG2-1 to 0.
- The buffer is not cleared on reset. FILL never subtracts buffer contents.
- The average is `sum >> AVG_LOG2` (truncating). The sum never overflows by construction.
- `sample_valid` pulses only for averages computed with a full window: the completing drdy and every later drdy.
- Comparator, evaluated on each `sample_valid`:
  - avg < LOW_TH gives candidate low.
  - avg > HIGH_TH gives candidate high.
  - Otherwise the result is in-band (hold).
  - Equality with either threshold counts as in-band.
- Without debounce, a candidate opposite to `voltage_low` flips it immediately.
- AVG_LOG2=0 means a window of 1: RUN is entered on the first sample.

## Timing
- Reset values: `sample_out`=0, `sample_valid`=0, `window_full`=0, `voltage_low`=0. The pointer, fill counter, sum and debounce counter also reset to 0.
- Pipeline, for `drdy_in` high at cycle N:
  - The sum is updated at N+1.
  - `sample_out`/`sample_valid` are registered at N+2.
  - `voltage_low` updates at N+3.
- `drdy_in` may be high on consecutive cycles. Every strobe is accepted, with no backpressure and no drops.
- `window_full` rises at N+1 of the completing drdy.
- `reset_in` at any cycle, including mid-pipeline or mid-fill:
  - The FSM returns to FILL.
  - In-flight results are discarded; no `sample_valid` follows.
  - `voltage_low` returns to 0.
- `drdy_in` is ignored during reset.

## Configuration
- ADC_FILT_DEBOUNCE_EN defined:
  - A 4-bit counter increments on each `sample_valid` whose candidate opposes `voltage_low`.
  - The counter clears on an in-band or agreeing average.
  - When the increment would reach DEBOUNCE, `voltage_low` flips (N+3 of that sample) and the counter clears.
- ADC_FILT_DEBOUNCE_EN undefined: no counter; flips are immediate; DEBOUNCE is ignored.

## Test plan
All scenarios use AVG_LOG2=3 and default thresholds unless stated.
- **Fill:** reset, then 8 drdy with `do_in`=16'hE000. No `sample_valid` for the first 7. The 8th gives `sample_valid` with `sample_out`=12'hE00 at N+2. `voltage_low`=1 at N+3 when debounce is undefined.
- **Hysteresis:** from low, 8 samples 12'hE20 leave `voltage_low`=1. Then 12'hE3C samples: `voltage_low` stays 1 at average E3C. Then 12'hE3D samples: `voltage_low` drops to 0 once the average exceeds E3C.
- **Averaging:** alternating 12'hE00/12'hE40 gives `sample_out`=12'hE20 on every valid, and `voltage_low` holds its prior value.
- **Throughput:** `drdy_in` held high for 20 cycles after reset gives exactly 13 `sample_valid` pulses on consecutive cycles, starting at cycle 10.
- **Debounce** (ADC_FILT_DEBOUNCE_EN, DEBOUNCE=4, window full at E20): 3 averages below E1A then one in-band gives no flip. Then 4 consecutive averages below E1A: `voltage_low`=1 at N+3 of the 4th.
- **Reset mid-fill:** reset after 5 samples gives `window_full`=0. No `sample_valid` until 8 new samples. Pre-reset data does not affect `sample_out`.
